// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain / serial transmitter slice.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 16;
    localparam int unsigned FIFO_PTR_W  = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    localparam logic IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_RD     = ST_RD,
        S_WAIT   = ST_WAIT,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

    // States before the first serial bit; the baud counter is held cleared here.
    function automatic logic is_pre_frame(input state_t s);
        return (s == S_IDLE) || (s == S_RD) || (s == S_WAIT);
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_gen.sv
// Bit-period timer: tick is high on the last clk of every CLKS_PER_BIT window.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    // Next count: wraps at LAST, forced to zero while cleared.
    always_comb begin
        w_cnt_nxt = '0;
        if (!clr && (r_cnt != LAST)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter and look-ahead tick so tick lines up with the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= !clr && (w_cnt_nxt == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a FIFO one word at a time and sends each word as a UART-style frame.
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = FIFO_DATA_W,
    parameter int unsigned PTR_W        = FIFO_PTR_W,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PTR_W-1:0]  wrptr,
    input  logic [PTR_W-1:0]  rdptr,
    input  logic [DATA_W-1:0] din,
    output logic              rd,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [BIT_W-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic              r_par, w_par_nxt;
    logic              r_rd, r_tx, r_busy, r_done;
    logic              w_rd_nxt, w_tx_nxt, w_busy_nxt, w_done_nxt;
    logic              w_tick;
    logic              w_clr;

    assign w_clr = is_pre_frame(r_state);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Next-state, datapath and output decode; outputs follow the next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_done_nxt   = 1'b0;
        w_rd_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_tx_nxt     = IDLE_LVL;

        unique case (r_state)
            S_IDLE: begin
                if (en && (wrptr != rdptr)) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_shreg_nxt  = din;
                w_par_nxt    = (^din) ^ (PARITY_ODD != 0);
                w_bitcnt_nxt = '0;
                w_state_nxt  = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nxt = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_rd_nxt   = (w_state_nxt == S_RD);
        w_busy_nxt = (w_state_nxt != S_IDLE);

        unique case (w_state_nxt)
            S_START:  w_tx_nxt = ~IDLE_LVL;
            S_DATA:   w_tx_nxt = w_shreg_nxt[0];
            S_PARITY: w_tx_nxt = w_par_nxt;
            default:  w_tx_nxt = IDLE_LVL;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_rd     <= 1'b0;
            r_tx     <= IDLE_LVL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            r_rd     <= w_rd_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign rd   = r_rd;
    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: three DUTs (no parity, even, odd) each fed by a FIFO model.
`timescale 1ns/1ps
module tb_fifo_serial_tx;

    localparam int unsigned CPB = 4;

    typedef struct {
        int unsigned dut;
        logic [18:0] bits;
        int unsigned nbits;
    } frame_t;

    typedef struct {
        int unsigned dut;
        logic [15:0] word;
        logic        par;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_w   [3];
    logic        rd_w   [3];
    logic        tx_w   [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        wr     [3];
    logic [15:0] wdata  [3];
    logic [3:0]  wp     [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0]  rp     [3] = '{4'd0, 4'd0, 4'd0};
    logic [15:0] dout   [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] mem    [3][16];

    frame_t sb_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     rd_cnt0  = 0;

    always #5 clk = ~clk;

    // FIFO models: registered dout, valid the cycle after rd is sampled.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr[k]) begin
                mem[k][wp[k]] <= wdata[k];
                wp[k]         <= wp[k] + 4'd1;
            end
            if (rd_w[k] === 1'b1) begin
                dout[k] <= mem[k][rp[k]];
                rp[k]   <= rp[k] + 4'd1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_w[0] === 1'b1) rd_cnt0 <= rd_cnt0 + 1;
    end

    fifo_serial_tx #(.DATA_W(16), .PTR_W(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en_w[0]), .wrptr(wp[0]), .rdptr(rp[0]), .din(dout[0]),
        .rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    fifo_serial_tx #(.DATA_W(16), .PTR_W(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en_w[1]), .wrptr(wp[1]), .rdptr(rp[1]), .din(dout[1]),
        .rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    fifo_serial_tx #(.DATA_W(16), .PTR_W(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en_w[2]), .wrptr(wp[2]), .rdptr(rp[2]), .din(dout[2]),
        .rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fifo_write(input int k, input logic [15:0] d);
        wr[k]    = 1'b1;
        wdata[k] = d;
        @(negedge clk);
        wr[k]    = 1'b0;
    endtask

    // Expected line image: start, data LSB first, optional parity, stop.
    function automatic void push_exp(input int unsigned k, input logic [15:0] w,
                                     input logic pe, input logic par);
        frame_t f;
        f.dut     = k;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 16; i++) f.bits[i+1] = w[i];
        if (pe) begin
            f.bits[17] = par;
            f.bits[18] = 1'b1;
            f.nbits    = 19;
        end else begin
            f.bits[17] = 1'b1;
            f.nbits    = 18;
        end
        sb_q.push_back(f);
    endfunction

    // Follows one frame of DUT k from rd to done; ends on the done cycle.
    task automatic expect_frame(input int k, output int wait_cyc, output int rd_t);
        frame_t f;
        int     bad_tx;
        int     bad_ctl;
        wait_cyc = -1;
        rd_t     = 0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        f = sb_q.pop_front();
        chk($sformatf("sb_dut%0d", k), 32'(f.dut), 32'(k));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_w[k] === 1'b1) begin
                wait_cyc = i;
                break;
            end
        end
        if (wait_cyc < 0) begin
            chk($sformatf("rd_timeout_dut%0d", k), 32'd0, 32'd1);
            return;
        end
        rd_t = cyc;
        chk($sformatf("done_low_at_rd_dut%0d", k), 32'(done_w[k]), 32'd0);
        chk($sformatf("tx_high_at_rd_dut%0d", k), 32'(tx_w[k]), 32'd1);
        @(negedge clk);
        chk($sformatf("rd_one_cycle_dut%0d", k), 32'(rd_w[k]), 32'd0);
        chk($sformatf("tx_high_wait_dut%0d", k), 32'(tx_w[k]), 32'd1);
        chk($sformatf("busy_wait_dut%0d", k), 32'(busy_w[k]), 32'd1);
        bad_tx  = 0;
        bad_ctl = 0;
        for (int i = 0; i < int'(f.nbits) * int'(CPB); i++) begin
            @(negedge clk);
            if (tx_w[k] !== f.bits[i / int'(CPB)]) bad_tx++;
            if (rd_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) bad_ctl++;
        end
        chk($sformatf("frame_bits_dut%0d", k), 32'(bad_tx), 32'd0);
        chk($sformatf("frame_ctrl_dut%0d", k), 32'(bad_ctl), 32'd0);
        @(negedge clk);
        chk($sformatf("done_pulse_dut%0d", k), 32'(done_w[k]), 32'd1);
        chk($sformatf("tx_after_stop_dut%0d", k), 32'(tx_w[k]), 32'd1);
        chk($sformatf("busy_after_stop_dut%0d", k), 32'(busy_w[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[8];
        int          w1, w2, w3, t1, t2, t3;
        int          lows, rdc;
        logic [3:0]  rp_start;

        for (int k = 0; k < 3; k++) begin
            en_w[k]  = 1'b0;
            wr[k]    = 1'b0;
            wdata[k] = 16'd0;
        end

        vecs[0] = '{0, 16'h0000, 1'b0};
        vecs[1] = '{0, 16'hFFFF, 1'b0};
        vecs[2] = '{0, 16'h8001, 1'b0};
        vecs[3] = '{1, 16'hA5C3, 1'b0};
        vecs[4] = '{2, 16'hA5C3, 1'b1};
        vecs[5] = '{1, 16'h0007, 1'b1};
        vecs[6] = '{2, 16'h0007, 1'b0};
        vecs[7] = '{2, 16'h0000, 1'b1};

        // Reset asserted at t=2 takes effect without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_rd", 32'(rd_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_tx_par", 32'(tx_w[2]), 32'd1);

        @(negedge clk);
        fifo_write(0, 16'hA5C3);
        push_exp(0, 16'hA5C3, 1'b0, 1'b0);
        rst = 1'b1;

        // Data waiting but en=0: line stays idle.
        lows = 0;
        rdc  = rd_cnt0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) lows++;
        end
        chk("en0_idle_line", 32'(lows), 32'd0);
        chk("en0_no_rd", 32'(rd_cnt0 - rdc), 32'd0);

        // Single word A5C3.
        en_w[0] = 1'b1;
        expect_frame(0, w1, t1);
        chk("single_rd_latency", 32'(w1), 32'd0);
        en_w[0] = 1'b0;

        // Empty FIFO with en=1 for 100 cycles.
        en_w[0] = 1'b1;
        lows = 0;
        rdc  = rd_cnt0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) lows++;
        end
        chk("empty_tx_high", 32'(lows), 32'd0);
        chk("empty_no_rd", 32'(rd_cnt0 - rdc), 32'd0);
        en_w[0] = 1'b0;

        // Table of single frames across the three parity configurations.
        for (int v = 0; v < 8; v++) begin
            fifo_write(int'(vecs[v].dut), vecs[v].word);
            push_exp(vecs[v].dut, vecs[v].word, vecs[v].dut != 0, vecs[v].par);
            en_w[vecs[v].dut] = 1'b1;
            expect_frame(int'(vecs[v].dut), w1, t1);
            en_w[vecs[v].dut] = 1'b0;
        end

        // Three words back to back.
        rp_start = rp[0];
        rdc      = rd_cnt0;
        fifo_write(0, 16'h1234);
        push_exp(0, 16'h1234, 1'b0, 1'b0);
        fifo_write(0, 16'hBEEF);
        push_exp(0, 16'hBEEF, 1'b0, 1'b0);
        fifo_write(0, 16'h0F0F);
        push_exp(0, 16'h0F0F, 1'b0, 1'b0);
        en_w[0] = 1'b1;
        expect_frame(0, w1, t1);
        expect_frame(0, w2, t2);
        expect_frame(0, w3, t3);
        en_w[0] = 1'b0;
        chk("b2b_gap2", 32'(w2), 32'd0);
        chk("b2b_gap3", 32'(w3), 32'd0);
        chk("b2b_rd_space2", 32'(t2 - t1 >= 75), 32'd1);
        chk("b2b_rd_space3", 32'(t3 - t2 >= 75), 32'd1);
        chk("b2b_rdptr_adv", 32'(4'(rp[0] - rp_start)), 32'd3);
        chk("b2b_rd_count", 32'(rd_cnt0 - rdc), 32'd3);

        // en dropped mid-DATA with a second word queued.
        fifo_write(0, 16'h5A5A);
        push_exp(0, 16'h5A5A, 1'b0, 1'b0);
        fifo_write(0, 16'hC001);
        en_w[0] = 1'b1;
        fork
            expect_frame(0, w1, t1);
            begin
                repeat (25) @(negedge clk);
                en_w[0] = 1'b0;
            end
        join
        lows = 0;
        rdc  = rd_cnt0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
        end
        chk("endrop_idle", 32'(lows), 32'd0);
        chk("endrop_no_rd", 32'(rd_cnt0 - rdc), 32'd0);

        // Reset in the middle of DATA for the queued word.
        en_w[0] = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_w[0]), 32'd1);
        chk("midrst_busy", 32'(busy_w[0]), 32'd0);
        chk("midrst_rd", 32'(rd_w[0]), 32'd0);
        chk("midrst_done", 32'(done_w[0]), 32'd0);
        chk("midrst_state", 32'(u_dut0.r_state), 32'd0);
        @(negedge clk);
        en_w[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0) lows++;
        end
        chk("post_rst_idle", 32'(lows), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
